// File: rtl/ctl_unit_tx_field.sv
// rtl/ctl_unit_tx_field.sv - frames HEADER, LENGTH, payload bytes, TRAILER out to a byte-wide UART transmitter
module ctl_unit_tx_field #(
  parameter logic [7:0] HEADER  = 8'hFE,
  parameter logic [7:0] TRAILER = 8'hEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SENDSTART,
  input  logic [7:0] LENGTH,
  input  logic [7:0] DATAIN,
  input  logic       TXDONE,
  output logic       TXSTART,
  output logic [7:0] TXDATA,
  output logic [7:0] RDADDR,
  output logic       BUSYFLAG,
  output logic       DONEFLAG
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SENDHDR  = 4'd1,
    WAITHDR  = 4'd2,
    SENDLEN  = 4'd3,
    WAITLEN  = 4'd4,
    FETCH    = 4'd5,
    SENDDATA = 4'd6,
    WAITDATA = 4'd7,
    SENDEND  = 4'd8,
    WAITEND  = 4'd9,
    DONE     = 4'd10
  } state_t;

  state_t     state;
  logic [7:0] count;
  logic [7:0] index;

  assign RDADDR = index;

  // TXSTART/TXDATA are set on the edge entering a SEND state, so the byte is already stable when TXSTART rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      TXSTART  <= 1'b0;
      TXDATA   <= 8'h00;
      BUSYFLAG <= 1'b0;
      DONEFLAG <= 1'b0;
      count    <= 8'h00;
      index    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          DONEFLAG <= 1'b0;
          if (SENDSTART) begin
            count    <= LENGTH;
            index    <= 8'h00;
            TXDATA   <= HEADER;
            TXSTART  <= 1'b1;
            BUSYFLAG <= 1'b1;
            state    <= SENDHDR;
          end
        end
        SENDHDR: begin
          TXSTART <= 1'b0;
          state   <= WAITHDR;
        end
        WAITHDR: begin
          if (TXDONE) begin
            TXDATA  <= count;
            TXSTART <= 1'b1;
            state   <= SENDLEN;
          end
        end
        SENDLEN: begin
          TXSTART <= 1'b0;
          state   <= WAITLEN;
        end
        WAITLEN: begin
          if (TXDONE) begin
            if (count != 8'h00) begin
              state <= FETCH;
            end else begin
              TXDATA  <= TRAILER;
              TXSTART <= 1'b1;
              state   <= SENDEND;
            end
          end
        end
        FETCH: begin
          TXDATA  <= DATAIN;
          TXSTART <= 1'b1;
          state   <= SENDDATA;
        end
        SENDDATA: begin
          TXSTART <= 1'b0;
          state   <= WAITDATA;
        end
        WAITDATA: begin
          if (TXDONE) begin
            if (index == count - 8'd1) begin
              TXDATA  <= TRAILER;
              TXSTART <= 1'b1;
              state   <= SENDEND;
            end else begin
              index <= index + 8'd1;
              state <= FETCH;
            end
          end
        end
        SENDEND: begin
          TXSTART <= 1'b0;
          state   <= WAITEND;
        end
        WAITEND: begin
          if (TXDONE) begin
            BUSYFLAG <= 1'b0;
            DONEFLAG <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          DONEFLAG <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          // illegal encoding: recover to a clean idle, as if freshly reset
          state    <= IDLE;
          TXSTART  <= 1'b0;
          TXDATA   <= 8'h00;
          BUSYFLAG <= 1'b0;
          DONEFLAG <= 1'b0;
          count    <= 8'h00;
          index    <= 8'h00;
        end
      endcase
    end
  end

endmodule
